core_wb_arbiter: RTL and testbench
==================================

CORE_WB_ARBITER -- requirements
Module: core_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of entries in the load-result buffer (power of two, at least 2).
REQ-002 SHALL have input clk, 1 bit: the clock; all state updates occur on the rising edge.
REQ-003 SHALL have input rst, 1 bit: the reset, synchronous and active-high.
REQ-004 SHALL have input ex_we_in, 1 bit: the EX-stage write request, held for 1 cycle with no handshake.
REQ-005 SHALL have inputs ex_addr_in (5 bits) and ex_data_in (32 bits): the EX destination register and result.
REQ-006 SHALL have input mem_valid_in, 1 bit: a load-result write request.
REQ-007 SHALL have output mem_ready_out, 1 bit: high when the buffer is not full.
REQ-008 SHALL have inputs mem_addr_in (5 bits) and mem_data_in (32 bits): the load destination register and data.
REQ-009 SHALL have outputs we_out (1 bit), write_addr_out (5 bits) and write_data_out (32 bits): the single register-file write port.
REQ-010 SHALL have inputs rd_addr1_in and rd_addr2_in, 5 bits each: the ID-stage source registers.
REQ-011 SHALL have output stall_out, 1 bit: a source register hits a pending buffered write.
REQ-012 SHALL have output count_out, clog2(DEPTH)+1 bits: the buffer occupancy.

Function
REQ-013 SHALL accept a MEM transfer on a cycle where mem_valid_in and mem_ready_out are both high, and SHALL ignore any transfer with mem_addr_in equal to 0.
REQ-014 SHALL store accepted MEM transfers in a FIFO of DEPTH entries, each holding an address and data.
REQ-015 SHALL give the write port fixed priority to EX: when ex_we_in is high and ex_addr_in is nonzero, the port carries the EX write in the same cycle (combinational, zero latency).
REQ-016 SHALL, when the EX write does not take the port and the FIFO is not empty, drive the FIFO head to the port and pop it at the clock edge.
REQ-017 SHALL NOT bypass an empty FIFO with a MEM write; every MEM write passes through the FIFO, so the minimum latency is 1 cycle.
REQ-018 SHALL drive we_out low, write_addr_out 0 and write_data_out 0 when no write is selected.
REQ-019 SHALL, on a simultaneous push and pop, update the FIFO pointers and leave count unchanged.
REQ-020 SHALL allow a push on a cycle when the FIFO is full and a pop occurs in the same cycle; mem_ready_out is computed from registered count only (count < DEPTH).
REQ-021 SHALL wrap the FIFO pointers modulo DEPTH.
REQ-022 SHALL raise stall_out when rd_addr1_in or rd_addr2_in is nonzero and equals the address of any valid FIFO entry, including the entry being popped this cycle.
REQ-023 SHALL clear a pending mark when an EX write to the same address occurs while that address is still buffered; the buffered MEM write still retires later, in program order.
REQ-024 SHALL hold count_out at a value between 0 and DEPTH at all times.

Reset
REQ-025 SHALL, while rst is high at a clock edge, clear the pointers and count to 0 and all entry-valid bits to 0, which makes mem_ready_out 1 and stall_out 0.
REQ-026 SHALL drop buffered writes on a reset that occurs mid-operation, and SHALL drive we_out low in the reset cycle.

Structure
REQ-027 SHALL define the register address width (5), data width (32) and zero-register address in the shared core defines package.
REQ-028 SHALL implement the FIFO as one sub-module, core_wb_fifo, with push, pop, full, empty, head and a per-entry address/valid vector for the hazard compare.

Verification
REQ-029 SHALL be verified with: MEM push of x5=0xA5A5A5A5 with no EX activity -> we_out at the next cycle with x5 and 0xA5A5A5A5; count_out goes 1 then 0.
REQ-030 SHALL be verified with: EX writes x3 on every cycle for 3 cycles while MEM pushes x7 and then x8 -> mem_ready_out falls after the second push; x7 and then x8 are written in the two cycles after EX stops.
REQ-031 SHALL be verified with: a full FIFO (DEPTH=2) with a push and a pop in the same cycle -> both are accepted and count_out stays 2.
REQ-032 SHALL be verified with: a buffered write to x9 while rd_addr2_in=9 -> stall_out=1 until the cycle x9 is written to the port; rd_addr=0 -> stall_out=0.
REQ-033 SHALL be verified with: a MEM push to x0 -> no write and count_out stays 0; EX write to x0 -> we_out=0.
REQ-034 SHALL be verified with: rst asserted with 2 entries buffered -> in the next cycle count_out=0, we_out=0, mem_ready_out=1, and the dropped data is never written.

Source files
------------

// File: rtl/core_wb_arbiter_pkg.sv
// Shared core defines: register-file geometry used by the write-back arbiter.
package core_wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/core_wb_fifo.sv
// Load-result FIFO for the write-back arbiter; exposes per-entry address and
// pending bits so the ID stage can detect hazards against buffered writes.
module core_wb_fifo
  import core_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_in,
  input  logic                        pop_in,
  input  logic [REG_ADDR_W-1:0]       push_addr_in,
  input  logic [DATA_W-1:0]           push_data_in,
  input  logic                        clr_en_in,
  input  logic [REG_ADDR_W-1:0]       clr_addr_in,
  output logic                        full_out,
  output logic                        empty_out,
  output logic [REG_ADDR_W-1:0]       head_addr_out,
  output logic [DATA_W-1:0]           head_data_out,
  output logic [CNT_W-1:0]            count_out,
  output logic [DEPTH*REG_ADDR_W-1:0] entry_addr_out,
  output logic [DEPTH-1:0]            entry_vld_out
);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [REG_ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [DATA_W-1:0]     data_d [DEPTH];

  // Pending bits: a newer EX write to the same register retires the hazard,
  // but the entry itself still drains in order. Clear before pop/push so a
  // same-cycle push into a wrapped slot keeps its fresh mark.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    addr_d   = addr_q;
    data_d   = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_en_in && (addr_q[i] == clr_addr_in)) vld_d[i] = 1'b0;
    end
    if (pop_in) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push_in) begin
      addr_d[wr_ptr_q] = push_addr_in;
      data_d[wr_ptr_q] = push_data_in;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_in) - CNT_W'(pop_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_comb begin
    entry_addr_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr_out[i*REG_ADDR_W +: REG_ADDR_W] = addr_q[i];
    end
  end

  assign full_out      = (count_q == CNT_W'(DEPTH));
  assign empty_out     = (count_q == '0);
  assign head_addr_out = addr_q[rd_ptr_q];
  assign head_data_out = data_q[rd_ptr_q];
  assign count_out     = count_q;
  assign entry_vld_out = vld_q;

endmodule

// File: rtl/core_wb_arbiter.sv
// Register-file write-port arbiter: EX results win the port immediately,
// load results queue in a FIFO and drain on cycles EX leaves the port idle.
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_we_in,
  input  logic [REG_ADDR_W-1:0] ex_addr_in,
  input  logic [DATA_W-1:0]     ex_data_in,
  input  logic                  mem_valid_in,
  output logic                  mem_ready_out,
  input  logic [REG_ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0]     mem_data_in,
  output logic                  we_out,
  output logic [REG_ADDR_W-1:0] write_addr_out,
  output logic [DATA_W-1:0]     write_data_out,
  input  logic [REG_ADDR_W-1:0] rd_addr1_in,
  input  logic [REG_ADDR_W-1:0] rd_addr2_in,
  output logic                  stall_out,
  output logic [CNT_W-1:0]      count_out
);

  logic                        ex_take;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [REG_ADDR_W-1:0]       head_addr;
  logic [DATA_W-1:0]           head_data;
  logic [DEPTH*REG_ADDR_W-1:0] entry_addr;
  logic [DEPTH-1:0]            entry_vld;

  assign ex_take       = ex_we_in && (ex_addr_in != ZERO_REG);
  assign mem_ready_out = !fifo_full;
  assign fifo_pop      = !rst && !ex_take && !fifo_empty;
  // A full FIFO still takes a push when its head drains in the same cycle.
  assign fifo_push     = !rst && mem_valid_in && (mem_addr_in != ZERO_REG) &&
                         (mem_ready_out || fifo_pop);

  core_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push_in        (fifo_push),
    .pop_in         (fifo_pop),
    .push_addr_in   (mem_addr_in),
    .push_data_in   (mem_data_in),
    .clr_en_in      (ex_take),
    .clr_addr_in    (ex_addr_in),
    .full_out       (fifo_full),
    .empty_out      (fifo_empty),
    .head_addr_out  (head_addr),
    .head_data_out  (head_data),
    .count_out      (count_out),
    .entry_addr_out (entry_addr),
    .entry_vld_out  (entry_vld)
  );

  always_comb begin
    we_out         = 1'b0;
    write_addr_out = ZERO_REG;
    write_data_out = '0;
    if (rst) begin
      we_out = 1'b0;
    end else if (ex_take) begin
      we_out         = 1'b1;
      write_addr_out = ex_addr_in;
      write_data_out = ex_data_in;
    end else if (!fifo_empty) begin
      we_out         = 1'b1;
      write_addr_out = head_addr;
      write_data_out = head_data;
    end
  end

  // Hazard compare includes the head being popped this cycle.
  always_comb begin
    stall_out = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i]) begin
        if ((rd_addr1_in != ZERO_REG) &&
            (entry_addr[i*REG_ADDR_W +: REG_ADDR_W] == rd_addr1_in)) stall_out = 1'b1;
        if ((rd_addr2_in != ZERO_REG) &&
            (entry_addr[i*REG_ADDR_W +: REG_ADDR_W] == rd_addr2_in)) stall_out = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter (DEPTH=2) with hand-computed expectations.
module tb_core_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_we_in;
  logic [4:0]  ex_addr_in;
  logic [31:0] ex_data_in;
  logic        mem_valid_in;
  logic        mem_ready_out;
  logic [4:0]  mem_addr_in;
  logic [31:0] mem_data_in;
  logic        we_out;
  logic [4:0]  write_addr_out;
  logic [31:0] write_data_out;
  logic [4:0]  rd_addr1_in;
  logic [4:0]  rd_addr2_in;
  logic        stall_out;
  logic [1:0]  count_out;

  int checks = 0;
  int fails  = 0;

  core_wb_arbiter #(.DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_we_in       (ex_we_in),
    .ex_addr_in     (ex_addr_in),
    .ex_data_in     (ex_data_in),
    .mem_valid_in   (mem_valid_in),
    .mem_ready_out  (mem_ready_out),
    .mem_addr_in    (mem_addr_in),
    .mem_data_in    (mem_data_in),
    .we_out         (we_out),
    .write_addr_out (write_addr_out),
    .write_data_out (write_data_out),
    .rd_addr1_in    (rd_addr1_in),
    .rd_addr2_in    (rd_addr2_in),
    .stall_out      (stall_out),
    .count_out      (count_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    ex_we_in     = ew;
    ex_addr_in   = ea;
    ex_data_in   = ed;
    mem_valid_in = mv;
    mem_addr_in  = ma;
    mem_data_in  = md;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_addr1_in = 5'd0;
    rd_addr2_in = 5'd5;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (count_out !== 2'd0 || mem_ready_out !== 1'b1 || stall_out !== 1'b0 || we_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: count=%0d ready=%b stall=%b we=%b, required 0 1 0 0",
               count_out, mem_ready_out, stall_out, we_out);
    end
  endtask

  task automatic test_mem_single();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5A5A5);
    checks++;
    if (we_out !== 1'b0 || count_out !== 2'd0) begin
      fails++;
      $display("FAIL mem_no_bypass: we=%b count=%0d, required 0 0", we_out, count_out);
    end
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (count_out !== 2'd1 || we_out !== 1'b1 || write_addr_out !== 5'd5 ||
        write_data_out !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL mem_single_write: count=%0d we=%b addr=%0d data=%h, required 1 1 5 a5a5a5a5",
               count_out, we_out, write_addr_out, write_data_out);
    end
    step();
    checks++;
    if (count_out !== 2'd0 || we_out !== 1'b0) begin
      fails++;
      $display("FAIL mem_single_drain: count=%0d we=%b, required 0 0", count_out, we_out);
    end
  endtask

  task automatic test_ex_priority();
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd7, 32'h0000_0077);
    checks++;
    if (we_out !== 1'b1 || write_addr_out !== 5'd3 || write_data_out !== 32'h33 || mem_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL ex_prio_c0: we=%b addr=%0d data=%h ready=%b, required 1 3 33 1",
               we_out, write_addr_out, write_data_out, mem_ready_out);
    end
    step();
    drive(1'b1, 5'd3, 32'h0000_0034, 1'b1, 5'd8, 32'h0000_0088);
    checks++;
    if (write_addr_out !== 5'd3 || write_data_out !== 32'h34 || count_out !== 2'd1 || mem_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL ex_prio_c1: addr=%0d data=%h count=%0d ready=%b, required 3 34 1 1",
               write_addr_out, write_data_out, count_out, mem_ready_out);
    end
    step();
    drive(1'b1, 5'd3, 32'h0000_0035, 1'b0, 5'd0, 32'd0);
    checks++;
    if (mem_ready_out !== 1'b0 || count_out !== 2'd2 || write_addr_out !== 5'd3 || write_data_out !== 32'h35) begin
      fails++;
      $display("FAIL ex_prio_full: ready=%b count=%0d addr=%0d data=%h, required 0 2 3 35",
               mem_ready_out, count_out, write_addr_out, write_data_out);
    end
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (we_out !== 1'b1 || write_addr_out !== 5'd7 || write_data_out !== 32'h77) begin
      fails++;
      $display("FAIL ex_prio_drain_x7: we=%b addr=%0d data=%h, required 1 7 77",
               we_out, write_addr_out, write_data_out);
    end
    step();
    checks++;
    if (we_out !== 1'b1 || write_addr_out !== 5'd8 || write_data_out !== 32'h88 || count_out !== 2'd1) begin
      fails++;
      $display("FAIL ex_prio_drain_x8: we=%b addr=%0d data=%h count=%0d, required 1 8 88 1",
               we_out, write_addr_out, write_data_out, count_out);
    end
    step();
    checks++;
    if (we_out !== 1'b0 || count_out !== 2'd0) begin
      fails++;
      $display("FAIL ex_prio_idle: we=%b count=%0d, required 0 0", we_out, count_out);
    end
  endtask

  task automatic test_full_push_pop();
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'h0000_00A0);
    step();
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'h0000_00B0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h0000_00C0);
    checks++;
    if (mem_ready_out !== 1'b0 || count_out !== 2'd2 || write_addr_out !== 5'd10 || write_data_out !== 32'hA0) begin
      fails++;
      $display("FAIL full_pushpop_c0: ready=%b count=%0d addr=%0d data=%h, required 0 2 10 a0",
               mem_ready_out, count_out, write_addr_out, write_data_out);
    end
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (count_out !== 2'd2 || write_addr_out !== 5'd11 || write_data_out !== 32'hB0) begin
      fails++;
      $display("FAIL full_pushpop_count: count=%0d addr=%0d data=%h, required 2 11 b0",
               count_out, write_addr_out, write_data_out);
    end
    step();
    checks++;
    if (count_out !== 2'd1 || we_out !== 1'b1 || write_addr_out !== 5'd12 || write_data_out !== 32'hC0) begin
      fails++;
      $display("FAIL full_pushpop_x12: count=%0d we=%b addr=%0d data=%h, required 1 1 12 c0",
               count_out, we_out, write_addr_out, write_data_out);
    end
    step();
    checks++;
    if (count_out !== 2'd0 || we_out !== 1'b0) begin
      fails++;
      $display("FAIL full_pushpop_idle: count=%0d we=%b, required 0 0", count_out, we_out);
    end
  endtask

  task automatic test_stall();
    rd_addr1_in = 5'd0;
    rd_addr2_in = 5'd9;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h0000_0099);
    checks++;
    if (stall_out !== 1'b0) begin
      fails++;
      $display("FAIL stall_before_buffer: stall=%b, required 0", stall_out);
    end
    step();
    drive(1'b1, 5'd1, 32'h2, 1'b0, 5'd0, 32'd0);
    checks++;
    if (stall_out !== 1'b1 || count_out !== 2'd1) begin
      fails++;
      $display("FAIL stall_buffered: stall=%b count=%0d, required 1 1", stall_out, count_out);
    end
    rd_addr2_in = 5'd0;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      fails++;
      $display("FAIL stall_rd_zero: stall=%b, required 0", stall_out);
    end
    rd_addr2_in = 5'd9;
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (stall_out !== 1'b1 || we_out !== 1'b1 || write_addr_out !== 5'd9 || write_data_out !== 32'h99) begin
      fails++;
      $display("FAIL stall_on_pop: stall=%b we=%b addr=%0d data=%h, required 1 1 9 99",
               stall_out, we_out, write_addr_out, write_data_out);
    end
    step();
    checks++;
    if (stall_out !== 1'b0 || count_out !== 2'd0) begin
      fails++;
      $display("FAIL stall_released: stall=%b count=%0d, required 0 0", stall_out, count_out);
    end
  endtask

  task automatic test_ex_clears_pending();
    rd_addr1_in = 5'd0;
    rd_addr2_in = 5'd9;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h0000_0099);
    step();
    drive(1'b1, 5'd9, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
    checks++;
    if (stall_out !== 1'b1 || write_addr_out !== 5'd9 || write_data_out !== 32'h1234) begin
      fails++;
      $display("FAIL clr_ex_write: stall=%b addr=%0d data=%h, required 1 9 1234",
               stall_out, write_addr_out, write_data_out);
    end
    step();
    drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0);
    checks++;
    if (stall_out !== 1'b0 || count_out !== 2'd1) begin
      fails++;
      $display("FAIL clr_mark_cleared: stall=%b count=%0d, required 0 1", stall_out, count_out);
    end
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (we_out !== 1'b1 || write_addr_out !== 5'd9 || write_data_out !== 32'h99) begin
      fails++;
      $display("FAIL clr_mem_retires: we=%b addr=%0d data=%h, required 1 9 99",
               we_out, write_addr_out, write_data_out);
    end
    step();
    rd_addr2_in = 5'd0;
  endtask

  task automatic test_zero_reg();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    checks++;
    if (we_out !== 1'b0) begin
      fails++;
      $display("FAIL zero_mem_we: we=%b, required 0", we_out);
    end
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (count_out !== 2'd0 || we_out !== 1'b0) begin
      fails++;
      $display("FAIL zero_mem_ignored: count=%0d we=%b, required 0 0", count_out, we_out);
    end
    drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
    checks++;
    if (we_out !== 1'b0 || write_addr_out !== 5'd0 || write_data_out !== 32'd0) begin
      fails++;
      $display("FAIL zero_ex_ignored: we=%b addr=%0d data=%h, required 0 0 0",
               we_out, write_addr_out, write_data_out);
    end
    step();
  endtask

  task automatic test_reset_mid();
    rd_addr1_in = 5'd0;
    rd_addr2_in = 5'd20;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h0000_0200);
    step();
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd21, 32'h0000_0210);
    step();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (we_out !== 1'b0 || count_out !== 2'd2) begin
      fails++;
      $display("FAIL rstmid_in_reset: we=%b count=%0d, required 0 2", we_out, count_out);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (count_out !== 2'd0 || we_out !== 1'b0 || mem_ready_out !== 1'b1 || stall_out !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_after: count=%0d we=%b ready=%b stall=%b, required 0 0 1 0",
               count_out, we_out, mem_ready_out, stall_out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (we_out !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_dropped: cycle %0d we=%b addr=%0d, required we 0", i, we_out, write_addr_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mem_single();
    test_ex_priority();
    test_full_push_pop();
    test_stall();
    test_ex_clears_pending();
    test_zero_reg();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
